// File: rtl/pcc_pkg.sv
// pcc_pkg: shared flit layout, flit-type codes and generator state encoding for the PCC mesh.
package pcc_pkg;
  localparam int FLIT_W = 66;
  localparam int TYPE_MSB = 65;
  localparam int TYPE_LSB = 64;
  localparam int PNUM_MSB = 63;
  localparam int PNUM_LSB = 48;
  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_HEAD, ST_BODY, ST_TAIL, ST_GAP, ST_DONE} pg_state_t;
endpackage

// File: rtl/pcc_lfsr32.sv
// pcc_lfsr32: 32-bit Galois LFSR (x^32+x^22+x^2+x+1) that steps only when adv is high.
module pcc_lfsr32 #(
  parameter logic [31:0] SEED = 32'hACE1_0001,
  parameter logic [31:0] TAPS = 32'h8020_0003
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  output logic [31:0] state
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SEED;
    else if (adv) state <= {1'b0, state[31:1]} ^ (state[0] ? TAPS : 32'h0);
endmodule

// File: rtl/pcc_packet_gen.sv
// pcc_packet_gen: source-side PCC flit generator with valid/ready backpressure,
// inter-packet gaps and a packet budget.
module pcc_packet_gen
  import pcc_pkg::*;
#(
  parameter logic [15:0] PKT_LEN   = 16'd4,
  parameter logic [15:0] PKT_TOTAL = 16'd50,
  parameter logic [7:0]  GAP       = 8'd8,
  parameter logic [7:0]  SRC_ID    = 8'd0,
  parameter logic [7:0]  DEST_ID   = 8'd1,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [FLIT_W-1:0] data_o,
  output logic [15:0]       pkt_cnt_o,
  output logic              done_o
);
  pg_state_t   state, state_nx, after_eop;
  logic [15:0] pnum, fidx, fidx_nx, cnt_inc;
  logic [7:0]  gcnt;
  logic [31:0] lfsr;
  logic [1:0]  ftype;
  logic [47:0] payload;
  logic        xfer, eop;
  assign valid_o = state inside {ST_HEAD, ST_BODY, ST_TAIL};
  assign done_o  = state == ST_DONE;
  assign xfer    = valid_o & ready_i;
  assign eop     = xfer & (state == ST_TAIL | (state == ST_HEAD & PKT_LEN == 16'd1));
  assign cnt_inc = pkt_cnt_o + 16'd1;
  pcc_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .adv  (xfer & (state == ST_BODY | state == ST_TAIL)),
    .state(lfsr)
  );
  // With no gap configured the tail hands straight over to the enable check.
  always_comb begin
    after_eop = (PKT_TOTAL != 16'd0 && cnt_inc == PKT_TOTAL) ? ST_DONE :
                (GAP != 8'd0) ? ST_GAP : (en ? ST_HEAD : ST_IDLE);
    state_nx  = state;
    fidx_nx   = fidx;
    case (state)
      ST_IDLE: state_nx = en ? ST_HEAD : ST_IDLE;
      ST_HEAD: if (xfer) begin
        state_nx = PKT_LEN == 16'd1 ? after_eop : PKT_LEN == 16'd2 ? ST_TAIL : ST_BODY;
        fidx_nx  = 16'd1;
      end
      ST_BODY: if (xfer) begin
        state_nx = fidx == PKT_LEN - 16'd2 ? ST_TAIL : ST_BODY;
        fidx_nx  = fidx + 16'd1;
      end
      ST_TAIL: state_nx = xfer ? after_eop : ST_TAIL;
      ST_GAP:  state_nx = gcnt == GAP - 8'd1 ? (en ? ST_HEAD : ST_IDLE) : ST_GAP;
      default: state_nx = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= ST_IDLE;
      pnum      <= 16'h0001;
      fidx      <= 16'd0;
      gcnt      <= 8'd0;
      pkt_cnt_o <= 16'd0;
    end else begin
      state     <= state_nx;
      fidx      <= fidx_nx;
      gcnt      <= state == ST_GAP ? gcnt + 8'd1 : 8'd0;
      pnum      <= eop ? (pnum == 16'hFFFF ? 16'h0001 : pnum + 16'd1) : pnum;
      pkt_cnt_o <= eop ? cnt_inc : pkt_cnt_o;
    end
  // Idle bus reads all-zero so monitors see packet number 0 between flits.
  always_comb begin
    ftype   = state == ST_HEAD ? (PKT_LEN == 16'd1 ? FT_SINGLE : FT_HEAD) :
              state == ST_TAIL ? FT_TAIL : FT_BODY;
    payload = state == ST_HEAD ? {SRC_ID, DEST_ID, PKT_LEN, 16'h0000} : {fidx, lfsr};
    data_o  = '0;
    if (valid_o) begin
      data_o[TYPE_MSB:TYPE_LSB] = ftype;
      data_o[PNUM_MSB:PNUM_LSB] = pnum;
      data_o[PNUM_LSB-1:0]      = payload;
    end
  end
endmodule
